// File: rtl/hwag_pkg.sv
// Shared definitions for the crank-wheel tooth/gap capture logic.
package hwag_pkg;

  localparam int TEETH_DEFAULT = 58;
  localparam int WIDTH_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SEARCH = 2'd2,
    SYNC   = 2'd3
  } state_t;

endpackage

// File: rtl/sat_timer.sv
// Saturating up-counter: loads 1 on load, holds when disabled, carry at all-ones.
module sat_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  output logic [WIDTH-1:0] count,
  output logic             carry
);

  assign carry = &count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (ena) begin
      if (load) begin
        count <= WIDTH'(1);
      end else if (!carry) begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/tooth_period_capture.sv
// Measures tooth periods on a 60-2 style wheel and locks onto the missing-tooth gap.
//
// state  | meaning
// IDLE   | no reference edge yet (after reset or timer stall)
// FIRST  | one edge seen, next edge yields the first period
// SEARCH | periods valid, looking for a gap (period >= 2 * previous)
// SYNC   | gap found, tooth index tracks position on the wheel
module tooth_period_capture
  import hwag_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int TEETH = TEETH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cap_rise,
  input  logic             cap_fall,
  input  logic             edge_sel,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             gap,
  output logic             synced,
  output logic [5:0]       tooth,
  output logic             sync_err,
  output logic             stall
);

  localparam logic [5:0] LAST_TOOTH = 6'(TEETH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] timer;
  logic             carry;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [5:0]       tooth_q, tooth_d;
  logic             valid_q, valid_d;
  logic             gap_q, gap_d;
  logic             err_q, err_d;
  logic             stall_q, stall_d;
  logic             act;
  logic             gap_cond;

  assign act = ena & (edge_sel ? cap_rise : cap_fall);

  sat_timer #(.WIDTH(WIDTH)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .load  (act),
    .count (timer),
    .carry (carry)
  );

  // One extra bit so that 2*prev cannot wrap for large previous periods.
  assign gap_cond = {1'b0, timer} >= {prev_q, 1'b0};

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    period_d = period_q;
    tooth_d  = tooth_q;
    valid_d  = 1'b0;
    gap_d    = 1'b0;
    err_d    = 1'b0;
    stall_d  = stall_q;

    if (act) begin
      stall_d = 1'b0;
      if (state_q != IDLE) begin
        valid_d  = 1'b1;
        period_d = timer;
        prev_d   = timer;
      end
      unique case (state_q)
        IDLE:  state_d = FIRST;
        FIRST: state_d = SEARCH;
        SEARCH: begin
          if (gap_cond) begin
            gap_d   = 1'b1;
            tooth_d = '0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (tooth_q == LAST_TOOTH) begin
            if (gap_cond) begin
              gap_d   = 1'b1;
              tooth_d = '0;
            end else begin
              err_d   = 1'b1;
              state_d = SEARCH;
            end
          end else if (gap_cond) begin
            gap_d   = 1'b1;
            err_d   = 1'b1;
            state_d = SEARCH;
          end else begin
            tooth_d = tooth_q + 6'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (carry) begin
      // Wheel stopped: drop all history quietly, no sync_err.
      stall_d = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      period_q <= '0;
      tooth_q  <= '0;
      valid_q  <= 1'b0;
      gap_q    <= 1'b0;
      err_q    <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      period_q <= period_d;
      tooth_q  <= tooth_d;
      valid_q  <= valid_d;
      gap_q    <= gap_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign gap          = gap_q;
  assign synced       = (state_q == SYNC);
  assign tooth        = tooth_q;
  assign sync_err     = err_q;
  assign stall        = stall_q;

endmodule

// File: tb/tb_tooth_period_capture.sv
// Directed bench: 24-bit instance checked through a scoreboard, 8-bit instance for stall/overflow.
module tb_tooth_period_capture;

  typedef struct packed {
    logic [23:0] period;
    logic        gap;
    logic [5:0]  tooth;
    logic        synced;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, ena, cap_rise, cap_fall, edge_sel;
  logic [23:0] period;
  logic        period_valid, gap, synced, sync_err, stall;
  logic [5:0]  tooth;

  logic        rst8, ena8, rise8, fall8, sel8;
  logic [7:0]  period8;
  logic        valid8, gap8, synced8, err8, stall8;
  logic [5:0]  tooth8;

  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  tooth_period_capture dut (
    .clk(clk), .rst(rst), .ena(ena), .cap_rise(cap_rise), .cap_fall(cap_fall),
    .edge_sel(edge_sel), .period(period), .period_valid(period_valid), .gap(gap),
    .synced(synced), .tooth(tooth), .sync_err(sync_err), .stall(stall)
  );

  tooth_period_capture #(.WIDTH(8), .TEETH(58)) dut8 (
    .clk(clk), .rst(rst8), .ena(ena8), .cap_rise(rise8), .cap_fall(fall8),
    .edge_sel(sel8), .period(period8), .period_valid(valid8), .gap(gap8),
    .synced(synced8), .tooth(tooth8), .sync_err(err8), .stall(stall8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Active edge lands n cycles after the previous one; noise adds inactive-edge pulses.
  task automatic act_after(input int n, input bit noise);
    for (int i = 1; i < n; i++) begin
      if (noise && i == n / 2) begin
        if (edge_sel) cap_fall = 1'b1; else cap_rise = 1'b1;
      end
      @(posedge clk); #1;
      cap_rise = 1'b0; cap_fall = 1'b0;
    end
    if (edge_sel) cap_rise = 1'b1; else cap_fall = 1'b1;
    if (noise) begin cap_rise = 1'b1; cap_fall = 1'b1; end
    @(posedge clk); #1;
    cap_rise = 1'b0; cap_fall = 1'b0;
  endtask

  task automatic step(input int n, input bit noise, input logic [23:0] p, input logic g,
                      input logic [5:0] t, input logic s, input logic er);
    exp_t x;
    x.period = p; x.gap = g; x.tooth = t; x.synced = s; x.err = er;
    sb.push_back(x);
    act_after(n, noise);
  endtask

  task automatic act8_after(input int n);
    repeat (n - 1) @(posedge clk);
    #1 rise8 = 1'b1;
    @(posedge clk); #1;
    rise8 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (period_valid) begin
        check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("period", 32'(period), 32'(e.period));
          check("gap", 32'(gap), 32'(e.gap));
          check("tooth", 32'(tooth), 32'(e.tooth));
          check("synced", 32'(synced), 32'(e.synced));
          check("sync_err", 32'(sync_err), 32'(e.err));
        end
      end else begin
        check("no_stray_pulse", 32'({gap, sync_err}), 32'd0);
      end
    end
  end

  initial begin
    int  w;
    bit  seen;
    rst = 1'b1; ena = 1'b1; cap_rise = 1'b0; cap_fall = 1'b0; edge_sel = 1'b1;
    rst8 = 1'b1; ena8 = 1'b1; rise8 = 1'b0; fall8 = 1'b0; sel8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_period", 32'(period), 32'd0);
    check("rst_outputs", 32'({period_valid, gap, synced, sync_err, stall}), 32'd0);
    check("rst_tooth", 32'(tooth), 32'd0);
    mon_en = 1'b1;

    // Regular teeth, then two full revolutions with gaps
    act_after(100, 1'b0);
    for (int k = 0; k < 57; k++) step(100, 1'b0, 24'd100, 1'b0, 6'd0, 1'b0, 1'b0);
    step(300, 1'b0, 24'd300, 1'b1, 6'd0, 1'b1, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 57; k++) step(100, 1'b0, 24'd100, 1'b0, 6'(k), 1'b1, 1'b0);
      step(300, 1'b0, 24'd300, 1'b1, 6'd0, 1'b1, 1'b0);
    end

    // Unexpected gap at tooth 20, then resync
    for (int k = 1; k <= 20; k++) step(100, 1'b0, 24'd100, 1'b0, 6'(k), 1'b1, 1'b0);
    step(300, 1'b0, 24'd300, 1'b1, 6'd20, 1'b0, 1'b1);
    step(100, 1'b0, 24'd100, 1'b0, 6'd20, 1'b0, 1'b0);
    step(300, 1'b0, 24'd300, 1'b1, 6'd0, 1'b1, 1'b0);

    // Missing gap at tooth 57, then resync
    for (int k = 1; k <= 57; k++) step(100, 1'b0, 24'd100, 1'b0, 6'(k), 1'b1, 1'b0);
    step(100, 1'b0, 24'd100, 1'b0, 6'd57, 1'b0, 1'b1);
    step(300, 1'b0, 24'd300, 1'b1, 6'd0, 1'b1, 1'b0);

    // Compare boundary: 199 vs prev 100 is not a gap, 200 is
    step(100, 1'b0, 24'd100, 1'b0, 6'd1, 1'b1, 1'b0);
    step(199, 1'b0, 24'd199, 1'b0, 6'd2, 1'b1, 1'b0);
    step(100, 1'b0, 24'd100, 1'b0, 6'd3, 1'b1, 1'b0);
    step(200, 1'b0, 24'd200, 1'b1, 6'd3, 1'b0, 1'b1);

    // Edge select, inactive-edge noise and both edges high together
    step(100, 1'b1, 24'd100, 1'b0, 6'd3, 1'b0, 1'b0);
    edge_sel = 1'b0;
    step(150, 1'b1, 24'd150, 1'b0, 6'd3, 1'b0, 1'b0);
    step(300, 1'b1, 24'd300, 1'b1, 6'd0, 1'b1, 1'b0);

    // 40 disabled cycles (with an ignored edge) do not count toward the period
    repeat (49) @(posedge clk);
    #1 ena = 1'b0; cap_fall = 1'b1;
    @(posedge clk);
    #1 cap_fall = 1'b0;
    repeat (39) @(posedge clk);
    #1 ena = 1'b1;
    step(51, 1'b0, 24'd100, 1'b0, 6'd1, 1'b1, 1'b0);

    // Reset mid-revolution discards history and overrides an active edge
    repeat (30) @(posedge clk);
    #1 rst = 1'b1; cap_fall = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; cap_fall = 1'b0;
    check("midrst_period", 32'(period), 32'd0);
    check("midrst_synced", 32'(synced), 32'd0);
    check("midrst_tooth", 32'(tooth), 32'd0);
    act_after(40, 1'b0);
    step(100, 1'b0, 24'd100, 1'b0, 6'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("sb_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;

    // 8-bit instance: stall from reset after 255 idle cycles
    #1 rst8 = 1'b0;
    repeat (250) @(posedge clk);
    #1 check("stall_early", 32'(stall8), 32'd0);
    w = 0;
    while (!stall8 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("stall_set", 32'(stall8), 32'd1);
    check("stall_latency", 32'(w), 32'd6);

    act8_after(5);
    check("stall_cleared", 32'(stall8), 32'd0);
    check("idle_no_valid", 32'(valid8), 32'd0);
    act8_after(10);
    check("w8_first_valid", 32'({valid8, gap8}), 32'd2);
    check("w8_first_period", 32'(period8), 32'd10);
    act8_after(10);
    act8_after(30);
    check("w8_gap", 32'({valid8, gap8, synced8}), 32'd7);

    // Starvation while synced: back to IDLE, no sync_err, no period
    w = 0; seen = 1'b0;
    while (!stall8 && w < 300) begin
      @(posedge clk); #1; w++;
      seen = seen | err8 | valid8;
    end
    check("sync_stall", 32'(stall8), 32'd1);
    check("sync_stall_synced", 32'(synced8), 32'd0);
    check("sync_stall_quiet", 32'(seen), 32'd0);

    act8_after(3);
    check("restart_no_valid", 32'({valid8, stall8}), 32'd0);
    act8_after(128);
    check("w8_p128", 32'(period8), 32'd128);
    // Edge lands exactly on saturation: capture wins, 255 < 2*128 is no gap
    act8_after(255);
    check("w8_sat_period", 32'(period8), 32'd255);
    check("w8_sat_flags", 32'({valid8, gap8, stall8, err8}), 32'd8);
    act8_after(20);
    check("w8_search_valid", 32'(valid8), 32'd1);
    check("w8_search_period", 32'(period8), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tooth_period_capture.md
TOOTH_PERIOD_CAPTURE -- requirements
Module: tooth_period_capture

Interface
REQ-001 Parameter WIDTH, default 24, sets the width of the period timer and period outputs in clock cycles.
REQ-002 Parameter TEETH, default 58, is the number of physical teeth between two gaps (60-2 wheel).
REQ-003 clk  input  1  the single clock; all logic is rising-edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 ena  input  1  global enable; when low, the timer holds and edges are ignored.
REQ-006 cap_rise  input  1  one-cycle pulse from the upstream edge detector on a rising edge of the filtered sensor.
REQ-007 cap_fall  input  1  one-cycle pulse on a falling edge.
REQ-008 edge_sel  input  1  active edge select: 1 = cap_rise, 0 = cap_fall.
REQ-009 period  output  WIDTH  cycles between the last two active edges.
REQ-010 period_valid  output  1  one-cycle pulse when period updates.
REQ-011 gap  output  1  one-cycle pulse, qualified with period_valid, when the captured period is a gap.
REQ-012 synced  output  1  level, high in state SYNC.
REQ-013 tooth  output  6  tooth index since the last gap edge; valid while synced.
REQ-014 sync_err  output  1  one-cycle pulse on loss of sync.
REQ-015 stall  output  1  level, high once the timer saturates; cleared by the next active edge.

Function
REQ-016 Active edge: act = ena & (edge_sel ? cap_rise : cap_fall).
REQ-017 Timer: when ena=1 and act=0, it increments by 1 and saturates at all-ones; on act it loads 1; when ena=0, it holds.
REQ-018 Period: on act it captures the timer value, so edges N cycles apart give period=N; outputs are registered and appear one cycle after the act cycle.
REQ-019 prev holds the previous captured period and is updated on every capture in state FIRST and later.
REQ-020 Gap test: gap_cond = (period_new >= 2*prev), evaluated at WIDTH+1 bits with no truncation.
REQ-021 The state machine has states IDLE, FIRST, SEARCH and SYNC.
REQ-022 IDLE: on act -> FIRST, with no period_valid.
REQ-023 FIRST: on act -> capture period with period_valid, gap=0, then -> SEARCH.
REQ-024 SEARCH: on act -> capture; if gap_cond, pulse gap, set tooth=0 and go -> SYNC; otherwise stay.
REQ-025 SYNC: on act with tooth<TEETH-1 and !gap_cond -> tooth+1.
REQ-026 SYNC: on act with tooth==TEETH-1 and gap_cond -> pulse gap, tooth=0, stay in SYNC.
REQ-027 SYNC: an unexpected gap (tooth<TEETH-1) or a missing gap (tooth==TEETH-1 and !gap_cond) pulses sync_err and goes -> SEARCH; tooth holds; gap pulses only for an unexpected gap.
REQ-028 Saturation: when the timer reaches all-ones with act=0, set stall=1, go to IDLE from any state and clear synced; no sync_err pulse.
REQ-029 If saturation and act occur in the same cycle, act wins: normal capture with period = all-ones, and stall clears.
REQ-030 cap_rise and cap_fall both high: only the edge chosen by edge_sel counts.
REQ-031 A change of edge_sel takes effect on the next cycle; software resynchronises, and the block takes no special action.

Reset
REQ-032 rst=1 sets state=IDLE, timer=0, prev=0, period=0, tooth=0, and clears all pulses, synced and stall on the same clock edge.
REQ-033 rst overrides ena and act; a reset in the middle of a revolution discards all history.

Structure
REQ-034 A shared package hwag_pkg holds the state enum (IDLE/FIRST/SEARCH/SYNC) and the default constants TEETH_DEFAULT=58 and WIDTH_DEFAULT=24.
REQ-035 One sub-module, sat_timer (saturating counter with load-1, hold and sync reset, carry = all-ones), implements the timer; the FSM and compare stay in tooth_period_capture.

Verification
REQ-036 WIDTH=24: edges every 100 cycles -> period=100 from the 2nd edge on, gap never, synced=0.
REQ-037 TEETH=58: 57 periods of 100 then one of 300, repeated twice -> gap at the 300 period, synced=1, tooth 0..57, no sync_err.
REQ-038 While synced, a 300 period at tooth=20 -> gap and sync_err pulses, synced=0, state SEARCH.
REQ-039 While synced, a 100 period at tooth=57 -> sync_err, synced=0; the next 300 period -> resync with tooth=0.
REQ-040 WIDTH=8, no edges for 255 cycles -> stall=1, state IDLE; next edge -> stall=0, FIRST.
REQ-041 Compare boundary, prev=100: period 199 -> no gap; period 200 -> gap; prev=2^(WIDTH-1), period all-ones -> no gap (no overflow).
